draw_scheduler: RTL and testbench

- Sequences the two VGA pixel engines, the board-RAM redraw engine and the tetromino draw/erase engine, onto the single VGA write port.
- Accepts board-redraw and piece-move requests and latches them as pending jobs.
- Runs jobs one at a time: erase old piece, draw new piece, or redraw board.
- Muxes and aligns the X/Y/colour/plot signals and reports busy/done to the game FSM.

---
 rtl/draw_scheduler_pkg.sv | 32 +++
 rtl/draw_scheduler_if.sv | 23 ++
 rtl/draw_port_mux.sv | 75 +++++++
 rtl/draw_scheduler.sv | 173 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the draw scheduler slice.
// Optional build macro: DRAW_VSYNC_GATE_EN (job starts gated by frame_tick).
package draw_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOARD,
    ST_ERASE,
    ST_PIECE,
    ST_GAP
  } state_t;

  localparam int PIECE_PIXELS = 64;
  localparam int BOARD_PIXELS = 3840;

  localparam int PX_W   = 5;
  localparam int PY_W   = 6;
  localparam int COL_W  = 6;
  localparam int BLK_W  = 3;
  localparam int VGA_XW = 8;
  localparam int VGA_YW = 7;

  localparam logic [COL_W-1:0] BLACK = 6'b000000;

  // Piece placement as handed to the piece engine.
  typedef struct packed {
    logic [BLK_W-1:0] block;
    logic [PX_W-1:0]  x;
    logic [PY_W-1:0]  y;
  } piece_pos_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// Request/status handshake between the game FSM (master) and the scheduler.
interface draw_scheduler_if;
  import draw_scheduler_pkg::*;

  logic             req_board;
  logic             req_move;
  logic [BLK_W-1:0] move_block;
  logic [PX_W-1:0]  move_x;
  logic [PY_W-1:0]  move_y;
  logic             busy;
  logic             done;

  modport master (
    output req_board, req_move, move_block, move_x, move_y,
    input  busy, done
  );

  modport slave (
    input  req_board, req_move, move_block, move_x, move_y,
    output busy, done
  );

endinterface

// File: rtl/draw_port_mux.sv
// VGA write-port mux: aligns the board path with the RAM read latency and
// selects board or piece pixels onto X/Y/colour/plot, holding when idle.
module draw_port_mux
  import draw_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              board_en,
  input  logic              board_done,
  input  logic [VGA_XW-1:0] board_x,
  input  logic [VGA_YW-1:0] board_y,
  input  logic [COL_W-1:0]  ram_q,
  input  logic              piece_en,
  input  logic              piece_clear,
  input  logic              piece_done,
  input  logic [VGA_XW-1:0] piece_vx,
  input  logic [VGA_YW-1:0] piece_vy,
  input  logic [COL_W-1:0]  piece_colour,
  output logic [VGA_XW-1:0] X,
  output logic [VGA_YW-1:0] Y,
  output logic [COL_W-1:0]  colour,
  output logic              plot
);

  logic              board_vld_d;
  logic [VGA_XW-1:0] bx_d;
  logic [VGA_YW-1:0] by_d;
  logic              piece_vld_d;
  logic [VGA_XW-1:0] x_hold;
  logic [VGA_YW-1:0] y_hold;
  logic [COL_W-1:0]  c_hold;

  // Board address delayed one stage to meet ram_q; piece enable delayed to
  // meet the engine's registered pixel; last driven pixel kept for hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      board_vld_d <= 1'b0;
      bx_d        <= '0;
      by_d        <= '0;
      piece_vld_d <= 1'b0;
      x_hold      <= '0;
      y_hold      <= '0;
      c_hold      <= '0;
    end else begin
      board_vld_d <= board_en & ~board_done;
      bx_d        <= board_x;
      by_d        <= board_y;
      // Dropping on piece_done keeps the GAP cycle from plotting.
      piece_vld_d <= piece_en & ~piece_done;
      x_hold      <= X;
      y_hold      <= Y;
      c_hold      <= colour;
    end
  end

  // Output select: board pixel, piece pixel (black when erasing), or hold.
  always_comb begin
    plot   = 1'b0;
    X      = x_hold;
    Y      = y_hold;
    colour = c_hold;
    if (board_vld_d) begin
      plot   = 1'b1;
      X      = bx_d;
      Y      = by_d;
      colour = ram_q;
    end else if (piece_vld_d && !piece_done) begin
      plot   = 1'b1;
      X      = piece_vx;
      Y      = piece_vy;
      colour = piece_clear ? BLACK : piece_colour;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Draw scheduler: latches board/move requests and runs board redraw,
// piece erase and piece draw jobs one at a time on the VGA port.
// Optional macro DRAW_VSYNC_GATE_EN adds frame_tick gating of job starts.
module draw_scheduler
  import draw_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
`ifdef DRAW_VSYNC_GATE_EN
  input  logic              frame_tick,
`endif
  draw_scheduler_if.slave   req_if,
  output logic              board_en,
  input  logic [VGA_XW-1:0] board_x,
  input  logic [VGA_YW-1:0] board_y,
  input  logic [COL_W-1:0]  ram_q,
  input  logic              board_done,
  output logic              piece_en,
  output logic              piece_clear,
  output logic [BLK_W-1:0]  piece_block,
  output logic [PX_W-1:0]   piece_x,
  output logic [PY_W-1:0]   piece_y,
  input  logic [VGA_XW-1:0] piece_vx,
  input  logic [VGA_YW-1:0] piece_vy,
  input  logic [COL_W-1:0]  piece_colour,
  input  logic              piece_done,
  output logic [VGA_XW-1:0] X,
  output logic [VGA_YW-1:0] Y,
  output logic [COL_W-1:0]  colour,
  output logic              plot
);

  state_t     state, state_n;
  logic       pend_board, pend_board_n;
  logic       pend_move, pend_move_n;
  logic       cur_valid, cur_valid_n;
  piece_pos_t cur, cur_n;
  piece_pos_t new_pos, new_n;
  logic       chain, chain_n;     // GAP after ERASE goes straight to PIECE
  logic       from_gap;           // first IDLE cycle after a job
  logic       go;
  logic       done_c;

`ifdef DRAW_VSYNC_GATE_EN
  assign go = frame_tick;
`else
  assign go = 1'b1;
`endif

  // State and job bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pend_board <= 1'b0;
      pend_move  <= 1'b0;
      cur_valid  <= 1'b0;
      cur        <= '0;
      new_pos    <= '0;
      chain      <= 1'b0;
      from_gap   <= 1'b0;
    end else begin
      state      <= state_n;
      pend_board <= pend_board_n;
      pend_move  <= pend_move_n;
      cur_valid  <= cur_valid_n;
      cur        <= cur_n;
      new_pos    <= new_n;
      chain      <= chain_n;
      from_gap   <= (state == ST_GAP);
    end
  end

  // Next-state, job selection, engine enables and request latching.
  always_comb begin
    state_n      = state;
    pend_board_n = pend_board;
    pend_move_n  = pend_move;
    cur_valid_n  = cur_valid;
    cur_n        = cur;
    new_n        = new_pos;
    chain_n      = chain;
    board_en     = 1'b0;
    piece_en     = 1'b0;
    piece_clear  = 1'b0;
    done_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        done_c = from_gap & ~pend_board & ~pend_move;
        if (go) begin
          if (pend_board) begin
            state_n      = ST_BOARD;
            pend_board_n = 1'b0;
          end else if (pend_move && cur_valid) begin
            state_n = ST_ERASE;
          end else if (pend_move) begin
            state_n = ST_PIECE;
            cur_n   = new_pos;
          end
        end
      end
      ST_BOARD: begin
        board_en = 1'b1;
        if (board_done) begin
          state_n = ST_GAP;
          // Redraw wiped the piece; queue it again unless a newer move waits.
          if (cur_valid) begin
            pend_move_n = 1'b1;
            if (!pend_move) new_n = cur;
          end
        end
      end
      ST_ERASE: begin
        piece_en    = 1'b1;
        piece_clear = 1'b1;
        if (piece_done) begin
          state_n = ST_GAP;
          chain_n = 1'b1;
        end
      end
      ST_PIECE: begin
        piece_en = 1'b1;
        if (piece_done) begin
          state_n     = ST_GAP;
          cur_valid_n = 1'b1;
          pend_move_n = 1'b0;
        end
      end
      ST_GAP: begin
        if (chain) begin
          state_n = ST_PIECE;
          chain_n = 1'b0;
          cur_n   = new_pos;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // New requests win over any clear in the same cycle.
    if (req_if.req_board) pend_board_n = 1'b1;
    if (req_if.req_move) begin
      pend_move_n = 1'b1;
      new_n       = '{block: req_if.move_block, x: req_if.move_x, y: req_if.move_y};
    end
  end

  assign piece_block = cur.block;
  assign piece_x     = cur.x;
  assign piece_y     = cur.y;
  assign req_if.busy = (state != ST_IDLE) | pend_board | pend_move;
  assign req_if.done = done_c;

  draw_port_mux u_mux (
    .clk          (clk),
    .reset        (reset),
    .board_en     (board_en),
    .board_done   (board_done),
    .board_x      (board_x),
    .board_y      (board_y),
    .ram_q        (ram_q),
    .piece_en     (piece_en),
    .piece_clear  (piece_clear),
    .piece_done   (piece_done),
    .piece_vx     (piece_vx),
    .piece_vy     (piece_vy),
    .piece_colour (piece_colour),
    .X            (X),
    .Y            (Y),
    .colour       (colour),
    .plot         (plot)
  );

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with behavioural board/piece engines
// and a board RAM with one-cycle read latency.
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  draw_scheduler_if dif();

  logic        board_en, board_done, piece_en, piece_clear, piece_done, plot;
  logic [7:0]  board_x, piece_vx, X;
  logic [6:0]  board_y, piece_vy, Y;
  logic [5:0]  ram_q, piece_colour, colour, piece_y;
  logic [2:0]  piece_block;
  logic [4:0]  piece_x;
`ifdef DRAW_VSYNC_GATE_EN
  logic        frame_tick = 1'b1;
`endif

  draw_scheduler dut (
    .clk(clk), .reset(reset),
`ifdef DRAW_VSYNC_GATE_EN
    .frame_tick(frame_tick),
`endif
    .req_if(dif),
    .board_en(board_en), .board_x(board_x), .board_y(board_y), .ram_q(ram_q),
    .board_done(board_done),
    .piece_en(piece_en), .piece_clear(piece_clear), .piece_block(piece_block),
    .piece_x(piece_x), .piece_y(piece_y), .piece_vx(piece_vx), .piece_vy(piece_vy),
    .piece_colour(piece_colour), .piece_done(piece_done),
    .X(X), .Y(Y), .colour(colour), .plot(plot)
  );

  // Board engine: one pixel per enabled cycle, then done held high.
  int bcnt = 0;
  always @(posedge clk)
    if (!board_en) bcnt <= 0;
    else if (bcnt < BOARD_PIXELS) bcnt <= bcnt + 1;
  assign board_done = board_en && (bcnt == BOARD_PIXELS);
  assign board_x    = 8'(bcnt % 40);
  assign board_y    = 7'(bcnt / 40);

  function automatic logic [5:0] ram_f(input logic [7:0] x, input logic [6:0] y);
    return {x[2:0], y[2:0]} ^ 6'h15;
  endfunction

  // Board RAM plus the address one cycle back for checking alignment.
  logic [7:0] ref_bx;
  logic [6:0] ref_by;
  always @(posedge clk) begin
    ram_q  <= ram_f(board_x, board_y);
    ref_bx <= board_x;
    ref_by <= board_y;
  end

  // Piece engine: registered pixels on counts 1..64, done pulse on count 65.
  int pcnt = 0;
  always @(posedge clk)
    if (!piece_en) pcnt <= 0;
    else if (pcnt < PIECE_PIXELS + 2) pcnt <= pcnt + 1;
  assign piece_done   = (pcnt == PIECE_PIXELS + 1);
  assign piece_vx     = 8'(pcnt);
  assign piece_vy     = {1'b0, piece_y};
  assign piece_colour = piece_clear ? 6'd0 : 6'(piece_block) + 6'd40;

  typedef struct {
    int board_plots; int erase_plots; int draw_plots; int bad_pix;
    int done_cnt; int erase_jobs; int draw_jobs; int board_jobs;
  } stats_t;
  stats_t st = '{default: 0};
  logic [13:0] erase_pos = '0, draw_pos = '0;
  logic [5:0]  last_draw_col = '0;
  int          low_run = 0, last_gap = 0;
  logic        pen_q = 1'b0, ben_q = 1'b0;

  // Port monitor: counts plots/jobs/done pulses and flags misaligned pixels.
  always @(negedge clk) begin
    if (plot && board_en) begin
      st.board_plots++;
      if (X !== ref_bx || Y !== ref_by || colour !== ram_f(ref_bx, ref_by)) st.bad_pix++;
    end else if (plot && piece_en) begin
      if (piece_clear) begin
        st.erase_plots++;
        if (colour !== 6'd0) st.bad_pix++;
      end else begin
        st.draw_plots++;
        last_draw_col = colour;
      end
      if (X !== piece_vx || Y !== piece_vy) st.bad_pix++;
    end else if (plot === 1'b1) begin
      st.bad_pix++;
    end
    if (dif.done === 1'b1) st.done_cnt++;
    if (piece_en && !pen_q) begin
      if (piece_clear) begin
        st.erase_jobs++;
        erase_pos = {piece_block, piece_x, piece_y};
      end else begin
        st.draw_jobs++;
        draw_pos = {piece_block, piece_x, piece_y};
        last_gap = low_run;
      end
    end
    if (board_en && !ben_q) st.board_jobs++;
    low_run = (piece_en || board_en) ? 0 : low_run + 1;
    pen_q = piece_en;
    ben_q = board_en;
  end

  int checks = 0, failures = 0;

  task automatic pulse(input bit b, input bit m, input logic [2:0] blk,
                       input logic [4:0] x, input logic [5:0] y);
    @(posedge clk); #1;
    dif.req_board = b; dif.req_move = m;
    dif.move_block = blk; dif.move_x = x; dif.move_y = y;
    @(posedge clk); #1;
    dif.req_board = 1'b0; dif.req_move = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!dif.busy) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (board_en !== 1'b0) begin failures++; $display("FAIL reset_board_en got=%b exp=0", board_en); end
    checks++; if (piece_en !== 1'b0) begin failures++; $display("FAIL reset_piece_en got=%b exp=0", piece_en); end
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%b exp=0", plot); end
    checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dif.done); end
    checks++; if (X !== 8'd0 || Y !== 7'd0) begin failures++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", X, Y); end
    checks++; if (colour !== 6'd0) begin failures++; $display("FAIL reset_colour got=%0d exp=0", colour); end
  endtask

  task automatic test_first_move();
    stats_t s0 = st;
    bit ok;
    pulse(0, 1, 3'd3, 5'd4, 6'd0);
    @(negedge clk);
    checks++; if (dif.busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", dif.busy); end
    wait_idle(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL first_timeout busy still high"); end
    checks++; if (st.erase_jobs - s0.erase_jobs !== 0) begin failures++; $display("FAIL first_erase_jobs got=%0d exp=0", st.erase_jobs - s0.erase_jobs); end
    checks++; if (st.draw_plots - s0.draw_plots !== 64) begin failures++; $display("FAIL first_plots got=%0d exp=64", st.draw_plots - s0.draw_plots); end
    checks++; if (draw_pos !== {3'd3, 5'd4, 6'd0}) begin failures++; $display("FAIL first_pos got=%h exp=%h", draw_pos, {3'd3, 5'd4, 6'd0}); end
    checks++; if (last_draw_col !== 6'd43) begin failures++; $display("FAIL first_colour got=%0d exp=43", last_draw_col); end
    checks++; if (st.done_cnt - s0.done_cnt !== 1) begin failures++; $display("FAIL first_done got=%0d exp=1", st.done_cnt - s0.done_cnt); end
    checks++; if (st.bad_pix - s0.bad_pix !== 0) begin failures++; $display("FAIL first_bad_pix got=%0d exp=0", st.bad_pix - s0.bad_pix); end
  endtask

  task automatic test_move_erase();
    stats_t s0 = st;
    bit ok;
    pulse(0, 1, 3'd3, 5'd4, 6'd1);
    wait_idle(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL erase_timeout busy still high"); end
    checks++; if (st.erase_jobs - s0.erase_jobs !== 1) begin failures++; $display("FAIL erase_jobs got=%0d exp=1", st.erase_jobs - s0.erase_jobs); end
    checks++; if (erase_pos !== {3'd3, 5'd4, 6'd0}) begin failures++; $display("FAIL erase_pos got=%h exp=%h", erase_pos, {3'd3, 5'd4, 6'd0}); end
    checks++; if (st.erase_plots - s0.erase_plots !== 64) begin failures++; $display("FAIL erase_plots got=%0d exp=64", st.erase_plots - s0.erase_plots); end
    checks++; if (last_gap !== 1) begin failures++; $display("FAIL erase_gap got=%0d exp=1", last_gap); end
    checks++; if (draw_pos !== {3'd3, 5'd4, 6'd1}) begin failures++; $display("FAIL erase_draw_pos got=%h exp=%h", draw_pos, {3'd3, 5'd4, 6'd1}); end
    checks++; if (st.draw_plots - s0.draw_plots !== 64) begin failures++; $display("FAIL erase_draw_plots got=%0d exp=64", st.draw_plots - s0.draw_plots); end
    checks++; if (st.done_cnt - s0.done_cnt !== 1) begin failures++; $display("FAIL erase_done got=%0d exp=1", st.done_cnt - s0.done_cnt); end
    checks++; if (st.bad_pix - s0.bad_pix !== 0) begin failures++; $display("FAIL erase_bad_pix got=%0d exp=0", st.bad_pix - s0.bad_pix); end
  endtask

  task automatic test_board_and_move();
    stats_t s0;
    bit ok;
    test_reset();
    s0 = st;
    pulse(1, 1, 3'd5, 5'd2, 6'd10);
    wait_idle(6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bm_timeout busy still high"); end
    checks++; if (st.board_plots - s0.board_plots !== 3840) begin failures++; $display("FAIL bm_board_plots got=%0d exp=3840", st.board_plots - s0.board_plots); end
    checks++; if (st.board_jobs - s0.board_jobs !== 1) begin failures++; $display("FAIL bm_board_jobs got=%0d exp=1", st.board_jobs - s0.board_jobs); end
    checks++; if (st.erase_jobs - s0.erase_jobs !== 0) begin failures++; $display("FAIL bm_erase_jobs got=%0d exp=0", st.erase_jobs - s0.erase_jobs); end
    checks++; if (st.draw_jobs - s0.draw_jobs !== 1) begin failures++; $display("FAIL bm_draw_jobs got=%0d exp=1", st.draw_jobs - s0.draw_jobs); end
    checks++; if (draw_pos !== {3'd5, 5'd2, 6'd10}) begin failures++; $display("FAIL bm_draw_pos got=%h exp=%h", draw_pos, {3'd5, 5'd2, 6'd10}); end
    checks++; if (st.done_cnt - s0.done_cnt !== 1) begin failures++; $display("FAIL bm_done got=%0d exp=1", st.done_cnt - s0.done_cnt); end
    checks++; if (st.bad_pix - s0.bad_pix !== 0) begin failures++; $display("FAIL bm_bad_pix got=%0d exp=0", st.bad_pix - s0.bad_pix); end
  endtask

  task automatic test_moves_during_board();
    stats_t s0 = st;
    bit ok;
    pulse(1, 0, 3'd0, 5'd0, 6'd0);
    repeat (100) @(posedge clk);
    pulse(0, 1, 3'd1, 5'd1, 6'd1);
    repeat (200) @(posedge clk);
    pulse(0, 1, 3'd2, 5'd3, 6'd4);
    repeat (200) @(posedge clk);
    pulse(0, 1, 3'd6, 5'd7, 6'd20);
    @(negedge clk);
    checks++; if (board_en !== 1'b1) begin failures++; $display("FAIL mdb_in_board got=%b exp=1", board_en); end
    wait_idle(6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mdb_timeout busy still high"); end
    checks++; if (st.board_plots - s0.board_plots !== 3840) begin failures++; $display("FAIL mdb_board_plots got=%0d exp=3840", st.board_plots - s0.board_plots); end
    checks++; if (st.erase_jobs - s0.erase_jobs !== 1) begin failures++; $display("FAIL mdb_erase_jobs got=%0d exp=1", st.erase_jobs - s0.erase_jobs); end
    checks++; if (erase_pos !== {3'd5, 5'd2, 6'd10}) begin failures++; $display("FAIL mdb_erase_pos got=%h exp=%h", erase_pos, {3'd5, 5'd2, 6'd10}); end
    checks++; if (st.draw_jobs - s0.draw_jobs !== 1) begin failures++; $display("FAIL mdb_draw_jobs got=%0d exp=1", st.draw_jobs - s0.draw_jobs); end
    checks++; if (draw_pos !== {3'd6, 5'd7, 6'd20}) begin failures++; $display("FAIL mdb_draw_pos got=%h exp=%h", draw_pos, {3'd6, 5'd7, 6'd20}); end
    checks++; if (st.erase_plots - s0.erase_plots !== 64 || st.draw_plots - s0.draw_plots !== 64) begin
      failures++; $display("FAIL mdb_piece_plots got=%0d/%0d exp=64/64", st.erase_plots - s0.erase_plots, st.draw_plots - s0.draw_plots); end
    checks++; if (st.done_cnt - s0.done_cnt !== 1) begin failures++; $display("FAIL mdb_done got=%0d exp=1", st.done_cnt - s0.done_cnt); end
    checks++; if (st.bad_pix - s0.bad_pix !== 0) begin failures++; $display("FAIL mdb_bad_pix got=%0d exp=0", st.bad_pix - s0.bad_pix); end
  endtask

  task automatic test_reset_mid_piece();
    stats_t s0;
    bit ok = 1'b0;
    pulse(0, 1, 3'd4, 5'd9, 6'd30);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (piece_en && !piece_clear) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmp_piece_start timeout"); end
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (piece_en !== 1'b0) begin failures++; $display("FAIL rmp_piece_en got=%b exp=0", piece_en); end
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL rmp_plot got=%b exp=0", plot); end
    checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL rmp_busy got=%b exp=0", dif.busy); end
    checks++; if (X !== 8'd0 || colour !== 6'd0) begin failures++; $display("FAIL rmp_xc got=%0d,%0d exp=0,0", X, colour); end
    @(posedge clk); #1 reset = 1'b0;
    s0 = st;
    pulse(0, 1, 3'd2, 5'd2, 6'd2);
    wait_idle(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmp_timeout busy still high"); end
    checks++; if (st.erase_jobs - s0.erase_jobs !== 0) begin failures++; $display("FAIL rmp_erase_jobs got=%0d exp=0", st.erase_jobs - s0.erase_jobs); end
    checks++; if (st.draw_plots - s0.draw_plots !== 64) begin failures++; $display("FAIL rmp_draw_plots got=%0d exp=64", st.draw_plots - s0.draw_plots); end
  endtask

`ifdef DRAW_VSYNC_GATE_EN
  task automatic test_vsync_gate();
    bit ok;
    @(posedge clk); #1 frame_tick = 1'b0;
    pulse(1, 0, 3'd0, 5'd0, 6'd0);
    repeat (10) @(negedge clk);
    checks++; if (board_en !== 1'b0) begin failures++; $display("FAIL gate_held got=%b exp=0", board_en); end
    checks++; if (dif.busy !== 1'b1) begin failures++; $display("FAIL gate_busy got=%b exp=1", dif.busy); end
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (board_en !== 1'b1) begin failures++; $display("FAIL gate_start got=%b exp=1", board_en); end
    wait_idle(6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_timeout busy still high"); end
  endtask
`endif

  initial begin
    dif.req_board = 1'b0; dif.req_move = 1'b0;
    dif.move_block = '0; dif.move_x = '0; dif.move_y = '0;
    test_reset();
    test_first_move();
    test_move_erase();
    test_board_and_move();
    test_moves_during_board();
    test_reset_mid_piece();
`ifdef DRAW_VSYNC_GATE_EN
    test_vsync_gate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
